// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: request kinds,
// the JUMP region boundary and the request-buffer state encoding.
package pc_sequencer_pkg;

    // Request kinds presented on req_kind; 6 and 7 are illegal.
    localparam logic [2:0] KIND_SEQ    = 3'd0;
    localparam logic [2:0] KIND_BRANCH = 3'd1;
    localparam logic [2:0] KIND_JUMP   = 3'd2;
    localparam logic [2:0] KIND_JREG   = 3'd3;
    localparam logic [2:0] KIND_CALL   = 3'd4;
    localparam logic [2:0] KIND_RET    = 3'd5;

    // JUMP/CALL keep PC bits above this position and replace the rest.
    localparam int JUMP_REGION_LSB = 28;

    // Request buffer: empty, or holding one request that waits for a cache hit.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } buf_state_t;

    // Kinds above RET have no defined behaviour and are dropped on acceptance.
    function automatic logic is_illegal_kind(input logic [2:0] kind);
        return (kind > KIND_RET);
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; the count saturates at RAS_DEPTH. A pop on an empty stack is ignored.
module return_addr_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_push_data,
    output logic [WIDTH-1:0]           o_top,
    output logic [$clog2(RAS_DEPTH):0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]    r_ptr;      // next write slot; top is the slot below it
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_top_idx;
    logic             w_do_pop;

    assign w_top_idx = r_ptr - PW'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_count   = r_count;
    assign o_full    = (r_count == CW'(RAS_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer and occupancy; the pointer wraps so the oldest entry is reused.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_ptr <= r_ptr + PW'(1);
            if (!o_full) begin
                r_count <= r_count + CW'(1);
            end
        end else if (w_do_pop) begin
            r_ptr   <= r_ptr - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge i_clock) begin
        if (i_push) begin
            r_mem[r_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC mux, one-deep request buffer that
// waits out instruction-cache misses, and a return-address stack.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is the inverse of pending only, so it never depends on req_valid.
// A transferred request is applied immediately when hit is high, otherwise it
// is parked in the buffer and applied on the first edge with hit high.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       hit,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [2:0]                 req_kind,
    input  logic [15:0]                branch_offset,
    input  logic [25:0]                jump_index,
    input  logic [WIDTH-1:0]           reg_target,
    output logic [WIDTH-1:0]           out,
    output logic                       pending,
    output logic [$clog2(RAS_DEPTH):0] ras_count
);

    buf_state_t       r_state;
    logic [WIDTH-1:0] r_buf_target;   // target computed at capture time
    logic [WIDTH-1:0] r_buf_link;     // capture-time out + STEP, pushed by CALL
    logic [2:0]       r_buf_kind;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_branch_off;
    logic [WIDTH-1:0] w_jump_target;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_ras_top;
    logic [WIDTH-1:0] w_push_data;
    logic [2:0]       w_apply_kind;
    logic             w_accept;
    logic             w_legal;
    logic             w_apply_now;
    logic             w_capture;
    logic             w_apply_buf;
    logic             w_push;
    logic             w_pop;
    logic             w_ras_empty;
    logic             w_unused_ras_full;

    assign pending   = (r_state == ST_PENDING);
    assign req_ready = !pending;

    assign w_p           = out + WIDTH'(STEP);
    assign w_branch_off  = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign w_jump_target = {w_p[WIDTH-1:JUMP_REGION_LSB], jump_index, 2'b00};

    assign w_accept    = req_valid && req_ready;
    assign w_legal     = !is_illegal_kind(req_kind);
    assign w_apply_now = w_accept && w_legal && hit;
    assign w_capture   = w_accept && w_legal && !hit;
    assign w_apply_buf = pending && hit;

    // Next-PC mux for the request on the inputs, evaluated against current out.
    always_comb begin
        w_target = out;
        case (req_kind)
            KIND_SEQ:    w_target = w_p;
            KIND_BRANCH: w_target = w_p + w_branch_off;
            KIND_JUMP:   w_target = w_jump_target;
            KIND_CALL:   w_target = w_jump_target;
            KIND_JREG:   w_target = reg_target;
            KIND_RET:    w_target = w_ras_empty ? reg_target : w_ras_top;
            default:     w_target = out;
        endcase
    end

    // Stack side effects are committed when a request is applied, not captured.
    assign w_apply_kind = w_apply_buf ? r_buf_kind : req_kind;
    assign w_push       = (w_apply_now || w_apply_buf) && (w_apply_kind == KIND_CALL);
    assign w_pop        = (w_apply_now || w_apply_buf) && (w_apply_kind == KIND_RET);
    assign w_push_data  = w_apply_buf ? r_buf_link : w_p;

    return_addr_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_push_data),
        .o_top       (w_ras_top),
        .o_count     (ras_count),
        .o_full      (w_unused_ras_full),
        .o_empty     (w_ras_empty)
    );

    // Buffer state machine and PC register: apply on hit, park on miss.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            out          <= RESET_VECTOR;
            r_buf_target <= '0;
            r_buf_link   <= '0;
            r_buf_kind   <= KIND_SEQ;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_apply_now) begin
                        out <= w_target;
                    end else if (w_capture) begin
                        r_state      <= ST_PENDING;
                        r_buf_target <= w_target;
                        r_buf_link   <= w_p;
                        r_buf_kind   <= req_kind;
                    end
                end
                ST_PENDING: begin
                    if (hit) begin
                        r_state <= ST_IDLE;
                        out     <= r_buf_target;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
